// File: rtl/rotator_pkg.sv
// Shared types and defaults for the rotate sequencer slice: state encoding,
// rotate-direction constants and default datapath widths.
package rotator_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROTATE  = 2'd1,
    RESPOND = 2'd2
  } state_e;

endpackage

// File: rtl/rotator_sequencer_if.sv
// Requester command channels, response channel and busy flag of the rotate
// sequencer; slave is the sequencer side, master the requester/consumer side.
interface rotator_sequencer_if #(
  parameter int WIDTH = rotator_pkg::DEF_WIDTH,
  parameter int CNT_W = rotator_pkg::DEF_CNT_W
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic             req0_dir;
  logic [CNT_W-1:0] req0_steps;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic             req1_dir;
  logic [CNT_W-1:0] req1_steps;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic             busy;

  modport slave (
    input  req0_valid, req0_data, req0_dir, req0_steps,
    input  req1_valid, req1_data, req1_dir, req1_steps,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req0_valid, req0_data, req0_dir, req0_steps,
    output req1_valid, req1_data, req1_dir, req1_steps,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, busy
  );

endinterface

// File: rtl/rotate_step_reg.sv
// WIDTH-bit pattern register: parallel load, or one-position rotate per
// enabled cycle in the selected direction. Load wins over step.
module rotate_step_reg
  import rotator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step_en,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] rot_left;
  logic [WIDTH-1:0] rot_right;

  // Left: bit i takes bit i-1 (MSB wraps to LSB); right: bit i takes bit i+1.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rot
      assign rot_left[gi]  = q_reg[(gi + WIDTH - 1) % WIDTH];
      assign rot_right[gi] = q_reg[(gi + 1) % WIDTH];
    end
  endgenerate

  always_comb begin
    q_next = q_reg;
    if (load) begin
      q_next = load_data;
    end else if (step_en) begin
      q_next = (dir == DIR_LEFT) ? rot_left : rot_right;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/rotator_sequencer.sv
// Two-requester rotate command sequencer: arbitrate, rotate one step per clock,
// respond with the requester tag. Define ROTSEQ_RR_ARB_EN for round-robin arbitration.
module rotator_sequencer
  import rotator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  rotator_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_ROTATE  = ROTATE;
  localparam logic [1:0] ST_RESPOND = RESPOND;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             dir_reg, dir_next;
  logic             id_reg, id_next;

  logic             idle;
  logic             grant0, grant1;
  logic             ready0, ready1;
  logic             accept;
  logic             sel_dir;
  logic [WIDTH-1:0] sel_data;
  logic [CNT_W-1:0] sel_steps;
  logic [WIDTH-1:0] rot_q;

  assign idle = (state_reg == ST_IDLE);

`ifdef ROTSEQ_RR_ARB_EN
  // Remembers which requester won the last accept; 1 so req0 wins first contention.
  logic last_reg;

  assign grant0 = bus.req0_valid && (!bus.req1_valid || last_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else if (accept) begin
      last_reg <= grant1;
    end
  end
`else
  assign grant0 = bus.req0_valid;
`endif

  assign grant1 = bus.req1_valid && !grant0;

  // Gating with rst_n keeps ready low while reset is held with valid asserted.
  assign ready0 = rst_n && idle && grant0;
  assign ready1 = rst_n && idle && grant1;
  assign accept = ready0 || ready1;

  assign sel_data  = grant1 ? bus.req1_data  : bus.req0_data;
  assign sel_dir   = grant1 ? bus.req1_dir   : bus.req0_dir;
  assign sel_steps = grant1 ? bus.req1_steps : bus.req0_steps;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    id_next    = id_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          cnt_next   = sel_steps;
          dir_next   = sel_dir;
          id_next    = grant1;
          state_next = (sel_steps == '0) ? ST_RESPOND : ST_ROTATE;
        end
      end
      ST_ROTATE: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (bus.rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      dir_reg   <= DIR_RIGHT;
      id_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      id_reg    <= id_next;
    end
  end

  rotate_step_reg #(
    .WIDTH (WIDTH)
  ) u_step_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step_en   (state_reg == ST_ROTATE),
    .dir       (dir_reg),
    .load_data (sel_data),
    .q         (rot_q)
  );

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = (state_reg == ST_RESPOND);
  assign bus.rsp_data   = rot_q;
  assign bus.rsp_id     = id_reg;
  assign bus.busy       = !idle;

endmodule

// File: tb/tb_rotator_sequencer.sv
// Randomized self-checking bench for rotator_sequencer against an arithmetic
// rotate/arbitration model; follows ROTSEQ_RR_ARB_EN like the design.
`timescale 1ns/1ps
module tb_rotator_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rotator_sequencer_if #(.WIDTH(8), .CNT_W(4)) bus ();

  rotator_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int txn_no = 0;
  int model_last = 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rotation by s positions is rotation by s mod 8, done with plain shifts.
  function automatic logic [7:0] model_rot(input logic [7:0] d, input bit left, input int s);
    int k;
    int x;
    int r;
    k = s % 8;
    x = int'(d);
    if (left) r = (x << k) | (x >> (8 - k));
    else      r = (x >> k) | (x << (8 - k));
    return 8'(r & 255);
  endfunction

  function automatic int model_pick(input bit v0, input bit v1);
`ifdef ROTSEQ_RR_ARB_EN
    if (v0 && v1) return (model_last == 1) ? 0 : 1;
`endif
    return v0 ? 0 : 1;
  endfunction

  task automatic scramble();
    bus.req0_data  = 8'($urandom);
    bus.req0_dir   = 1'($urandom);
    bus.req0_steps = 4'($urandom);
    bus.req1_data  = 8'($urandom);
    bus.req1_dir   = 1'($urandom);
    bus.req1_steps = 4'($urandom);
  endtask

  // Called just after a rising edge with the DUT idle; returns just after the rsp handshake edge.
  task automatic do_txn(input bit v0, input bit v1,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input bit dr0, input bit dr1,
                        input logic [3:0] s0, input logic [3:0] s1,
                        input int hold);
    int w;
    int exp_s;
    int lat;
    int bad;
    logic [7:0] exp_d;
    logic [7:0] cap_d;
    logic       cap_id;
    bus.req0_valid = v0; bus.req0_data = d0; bus.req0_dir = dr0; bus.req0_steps = s0;
    bus.req1_valid = v1; bus.req1_data = d1; bus.req1_dir = dr1; bus.req1_steps = s1;
    bus.rsp_ready  = (hold == 0);
    w     = model_pick(v0, v1);
    exp_s = (w == 1) ? int'(s1) : int'(s0);
    exp_d = model_rot((w == 1) ? d1 : d0, (w == 1) ? dr1 : dr0, exp_s);

    @(negedge clk);
    check_val("idle_busy", bus.busy, 0);
    check_val("idle_rsp_valid", bus.rsp_valid, 0);
    check_val("ready0", bus.req0_ready, (w == 0));
    check_val("ready1", bus.req1_ready, (w == 1));
    @(posedge clk);
    model_last = w;

    lat = 0;
    bad = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) break;
      if (!bus.busy || bus.req0_ready || bus.req1_ready) bad++;
      scramble();
    end
    check_val("busy_rotate", bad, 0);
    check_val("latency", lat, exp_s + 1);
    check_val("rsp_data", bus.rsp_data, exp_d);
    check_val("rsp_id", bus.rsp_id, w);
    check_val("busy_respond", bus.busy, 1);
    check_val("ready_respond", {bus.req0_ready, bus.req1_ready}, 0);

    cap_d  = bus.rsp_data;
    cap_id = bus.rsp_id;
    bad    = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== cap_d || bus.rsp_id !== cap_id ||
          bus.req0_ready || bus.req1_ready) bad++;
      scramble();
    end
    if (hold > 0) check_val("hold_stable", bad, 0);

    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    txn_no++;
    $display("txn %0d: v0=%0b v1=%0b id=%0d steps=%0d data=%02h lat=%0d hold=%0d",
             txn_no, v0, v1, cap_id, exp_s, cap_d, lat, hold);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bit v0;
    bit v1;

    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b0;
    bus.req0_data = 8'h00; bus.req0_dir = 1'b0; bus.req0_steps = 4'd0;
    bus.req1_data = 8'h00; bus.req1_dir = 1'b0; bus.req1_steps = 4'd0;
    repeat (2) @(negedge clk);
    check_val("rst_ready0", bus.req0_ready, 0);
    check_val("rst_ready1", bus.req1_ready, 0);
    check_val("rst_rsp_valid", bus.rsp_valid, 0);
    check_val("rst_rsp_data", bus.rsp_data, 0);
    check_val("rst_rsp_id", bus.rsp_id, 0);
    check_val("rst_busy", bus.busy, 0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst_n = 1'b1;
    model_last = 1;
    @(posedge clk);
    #1;

    // Contention with rsp_ready effectively tied high.
    repeat (4) do_txn(1, 1, 8'h81, 8'h01, 1, 0, 4'd3, 4'd1, 0);

    do_txn(1, 0, 8'h81, 8'h00, 1, 0, 4'd3, 4'd0, 0);
    do_txn(0, 1, 8'h00, 8'h01, 0, 0, 4'd0, 4'd1, 0);
    do_txn(0, 1, 8'h00, 8'h0F, 0, 0, 4'd0, 4'd8, 0);
    do_txn(1, 0, 8'hA5, 8'h00, 0, 0, 4'd0, 4'd0, 0);
    do_txn(1, 0, 8'h3C, 8'h00, 1, 0, 4'd5, 4'd0, 5);

    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      do_txn(v0, v1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
             4'($urandom), 4'($urandom), $urandom_range(0, 3));
    end

    // Abort a long command with reset mid-rotation.
    bus.req0_valid = 1'b1; bus.req0_data = 8'h81; bus.req0_dir = 1'b1; bus.req0_steps = 4'd7;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", bus.busy, 0);
    check_val("abort_rsp_valid", bus.rsp_valid, 0);
    check_val("abort_rsp_data", bus.rsp_data, 0);
    check_val("abort_rsp_id", bus.rsp_id, 0);
    check_val("abort_ready0", bus.req0_ready, 0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;
    model_last = 1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.busy) seen++;
    end
    check_val("abort_no_rsp", seen, 0);
    @(posedge clk);
    #1;
    do_txn(1, 0, 8'h01, 8'h00, 1, 0, 4'd2, 4'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
